// File: rtl/seq_detect_pkg.sv
// Shared definitions for the 1101 serial pattern detector.
// Provides the state codes used by the external state register.
// Also provides a legality check for the fed-back state code.
package seq_detect_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] S_1     = 4'd1;
  localparam logic [STATE_W-1:0] S_11    = 4'd2;
  localparam logic [STATE_W-1:0] S_110   = 4'd3;
  localparam logic [STATE_W-1:0] S_MATCH = 4'd4;

  // Codes 5..15 are never produced by the next-state logic.
  function automatic logic is_legal(input logic [STATE_W-1:0] s);
    return (s <= S_MATCH);
  endfunction

endpackage

// File: rtl/seq_detect_ctl_regs.sv
// Register bank for Match pulse, saturating Match count, sticky Err and pause.
// Latency: all outputs update one edge after the qualifying event; no stall of its own.
// Backpressure: pause output, when enabled, drops In_ready for the single cycle after a match.
// Ports: clk/rst_n; clear, match_evt, illegal_evt in; match_q, match_count_q, err_q, pause_q out.
module seq_detect_ctl_regs #(
  parameter int CNT_W     = 8,
  parameter bit PAUSE_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             match_evt,
  input  logic             illegal_evt,
  output logic             match_q,
  output logic [CNT_W-1:0] match_count_q,
  output logic             err_q,
  output logic             pause_q
);

  logic             match_d;
  logic [CNT_W-1:0] match_count_d;
  logic             err_d;
  logic             pause_d;

  always_comb begin
    match_d       = 1'b0;
    match_count_d = match_count_q;
    err_d         = err_q;
    pause_d       = 1'b0;
    if (clear) begin
      // Clear overrides any simultaneous match or illegal-state event.
      match_count_d = '0;
      err_d         = 1'b0;
    end else begin
      match_d = match_evt;
      pause_d = match_evt & PAUSE_EN;
      // Saturate rather than wrap.
      if (match_evt && (match_count_q != {CNT_W{1'b1}})) begin
        match_count_d = match_count_q + 1'b1;
      end
      if (illegal_evt) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q       <= 1'b0;
      match_count_q <= '0;
      err_q         <= 1'b0;
      pause_q       <= 1'b0;
    end else begin
      match_q       <= match_d;
      match_count_q <= match_count_d;
      err_q         <= err_d;
      pause_q       <= pause_d;
    end
  end

endmodule

// File: rtl/seq_detect_next.sv
// Next-state/control stage for an external 4-bit state register detecting 1101 with overlap.
// Latency: next_state is combinational; Match/Match_count/Err are registered one edge later.
// Backpressure: In_ready = ~pause (low one cycle after a match) or tied high when pausing is off.
// Ports: Clk, Reset_n, In_valid/In_bit/In_ready, Clear, state in, next_state, Match, Match_count, Err.
module seq_detect_next
  import seq_detect_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter bit PAUSE_ON_MATCH = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               In_valid,
  input  logic               In_bit,
  output logic               In_ready,
  input  logic               Clear,
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] next_state,
  output logic               Match,
  output logic [CNT_W-1:0]   Match_count,
  output logic               Err
);

  logic accept;
  logic legal;
  logic match_evt;
  logic illegal_evt;
  logic pause_q;

  assign In_ready    = PAUSE_ON_MATCH ? ~pause_q : 1'b1;
  assign accept      = In_valid & In_ready;
  assign legal       = is_legal(state);
  assign illegal_evt = ~legal;
  // Only S_110 with an accepted 1 can enter S_MATCH; holding in S_MATCH is not a new match.
  assign match_evt   = accept & (state == S_110) & In_bit;

  always_comb begin
    next_state = state;
    if (!Reset_n) begin
      next_state = S_IDLE;
    end else if (Clear || !legal) begin
      // Any offered bit is consumed and dropped here.
      next_state = S_IDLE;
    end else if (accept) begin
      case (state)
        S_IDLE:  next_state = In_bit ? S_1     : S_IDLE;
        S_1:     next_state = In_bit ? S_11    : S_IDLE;
        S_11:    next_state = In_bit ? S_11    : S_110;
        S_110:   next_state = In_bit ? S_MATCH : S_IDLE;
        // Trailing 1 of a match is the first 1 of the next pattern, so 1 -> S_11.
        S_MATCH: next_state = In_bit ? S_11    : S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  seq_detect_ctl_regs #(
    .CNT_W    (CNT_W),
    .PAUSE_EN (PAUSE_ON_MATCH)
  ) u_ctl_regs (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .clear         (Clear),
    .match_evt     (match_evt),
    .illegal_evt   (illegal_evt),
    .match_q       (Match),
    .match_count_q (Match_count),
    .err_q         (Err),
    .pause_q       (pause_q)
  );

endmodule

// File: tb/tb_seq_detect_next.sv
// Directed bench for seq_detect_next: three instances (no pause, pause, 2-bit counter)
// share stimulus; each has its own model of the downstream state register.
// Inputs change 1 time unit after the rising edge, which is also when outputs are sampled.
module tb_seq_detect_next;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       In_valid;
  logic       In_bit;
  logic       Clear;
  logic       frc;
  logic [3:0] frc_val;

  logic [3:0] st0, st1, st2;
  logic [3:0] s_in0, s_in1, s_in2;
  logic [3:0] ns0, ns1, ns2;
  logic       rdy0, rdy1, rdy2;
  logic       m0, m1, m2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       err0, err1, err2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign s_in0 = frc ? frc_val : st0;
  assign s_in1 = frc ? frc_val : st1;
  assign s_in2 = frc ? frc_val : st2;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st0 <= 4'd0;
      st1 <= 4'd0;
      st2 <= 4'd0;
    end else begin
      st0 <= ns0;
      st1 <= ns1;
      st2 <= ns2;
    end
  end

  seq_detect_next #(.CNT_W(8), .PAUSE_ON_MATCH(1'b0)) u_p0 (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_bit(In_bit),
    .In_ready(rdy0), .Clear(Clear), .state(s_in0), .next_state(ns0),
    .Match(m0), .Match_count(cnt0), .Err(err0));

  seq_detect_next #(.CNT_W(8), .PAUSE_ON_MATCH(1'b1)) u_p1 (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_bit(In_bit),
    .In_ready(rdy1), .Clear(Clear), .state(s_in1), .next_state(ns1),
    .Match(m1), .Match_count(cnt1), .Err(err1));

  seq_detect_next #(.CNT_W(2), .PAUSE_ON_MATCH(1'b0)) u_sat (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_bit(In_bit),
    .In_ready(rdy2), .Clear(Clear), .state(s_in2), .next_state(ns2),
    .Match(m2), .Match_count(cnt2), .Err(err2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic feed(input logic b);
    In_valid = 1'b1;
    In_bit   = b;
    tick();
  endtask

  task automatic do_clear();
    In_valid = 1'b0;
    Clear    = 1'b1;
    tick();
    Clear    = 1'b0;
  endtask

  logic [6:0] ovl_bits;
  logic [6:0] ovl_match;
  logic [1:0] sat_exp [5];

  initial begin
    ovl_bits   = 7'b1011011;  // bit i is the i-th bit sent: 1,1,0,1,1,0,1
    ovl_match  = 7'b1001000;  // matches after bit 3 and bit 6
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    Reset_n  = 1'b0;
    In_valid = 1'b1;
    In_bit   = 1'b1;
    Clear    = 1'b0;
    frc      = 1'b0;
    frc_val  = 4'd0;

    // Reset held across edges with a valid 1 offered.
    tick();
    tick();
    chk("rst_match", {31'd0, m1}, 32'd0);
    chk("rst_cnt", {24'd0, cnt1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_rdy", {31'd0, rdy1}, 32'd1);
    chk("rst_ns", {28'd0, ns1}, 32'd0);
    chk("rst_st", {28'd0, st1}, 32'd0);
    Reset_n = 1'b1;

    // 1,1,0,1 -> single Match pulse one cycle after the final accept.
    feed(1'b1); chk("m_b0", {31'd0, m1}, 32'd0);
    feed(1'b1); chk("m_b1", {31'd0, m1}, 32'd0);
    feed(1'b0); chk("m_b2", {31'd0, m1}, 32'd0);
    feed(1'b1); chk("m_b3", {31'd0, m1}, 32'd1);
    chk("m_cnt", {24'd0, cnt1}, 32'd1);
    chk("m_st", {28'd0, st1}, 32'd4);

    // Pause: keep offering 1 while In_ready is low.
    chk("pause_rdy_lo", {31'd0, rdy1}, 32'd0);
    chk("pause_hold_ns", {28'd0, ns1}, 32'd4);
    chk("nopause_rdy", {31'd0, rdy0}, 32'd1);
    chk("nopause_ns", {28'd0, ns0}, 32'd2);
    feed(1'b1);
    chk("pause_m_once", {31'd0, m1}, 32'd0);
    chk("pause_rdy_hi", {31'd0, rdy1}, 32'd1);
    chk("pause_st_held", {28'd0, st1}, 32'd4);
    chk("pause_ns_s11", {28'd0, ns1}, 32'd2);
    feed(1'b1);
    chk("pause_st_s11", {28'd0, st1}, 32'd2);
    chk("pause_cnt", {24'd0, cnt1}, 32'd1);

    // Overlap on the non-pausing instance.
    Clear = 1'b1;
    In_valid = 1'b0;
    #1;
    chk("clr_ns", {28'd0, ns0}, 32'd0);
    tick();
    Clear = 1'b0;
    chk("clr_cnt", {24'd0, cnt0}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      feed(ovl_bits[i]);
      chk($sformatf("ovl_m%0d", i), {31'd0, m0}, {31'd0, ovl_match[i]});
    end
    chk("ovl_cnt", {24'd0, cnt0}, 32'd2);

    // Illegal state code forced onto the state inputs.
    In_valid = 1'b1;
    In_bit   = 1'b1;
    frc      = 1'b1;
    frc_val  = 4'hB;
    #1;
    chk("ill_ns", {28'd0, ns0}, 32'd0);
    chk("ill_err_pre", {31'd0, err0}, 32'd0);
    tick();
    chk("ill_err_set", {31'd0, err0}, 32'd1);
    chk("ill_no_match", {31'd0, m0}, 32'd0);
    tick();
    chk("ill_err_b2b", {31'd0, err0}, 32'd1);
    frc = 1'b0;
    feed(1'b1);
    chk("ill_err_sticky", {31'd0, err0}, 32'd1);
    chk("ill_st_legal", {28'd0, st0}, 32'd1);
    chk("ill_cnt_kept", {24'd0, cnt0}, 32'd2);
    do_clear();
    chk("clr_err", {31'd0, err0}, 32'd0);
    chk("clr_cnt2", {24'd0, cnt0}, 32'd0);

    // Clear on the same cycle as the final accepted 1.
    feed(1'b1);
    feed(1'b1);
    feed(1'b0);
    chk("cv_st110", {28'd0, st0}, 32'd3);
    In_valid = 1'b1;
    In_bit   = 1'b1;
    Clear    = 1'b1;
    #1;
    chk("cv_ns", {28'd0, ns0}, 32'd0);
    tick();
    Clear = 1'b0;
    chk("cv_match", {31'd0, m0}, 32'd0);
    chk("cv_cnt", {24'd0, cnt0}, 32'd0);
    chk("cv_st", {28'd0, st0}, 32'd0);

    // Reset pulse after 1,1,0 loses progress.
    feed(1'b1);
    feed(1'b1);
    feed(1'b0);
    Reset_n = 1'b0;
    #1;
    chk("rp_st", {28'd0, st0}, 32'd0);
    chk("rp_ns", {28'd0, ns0}, 32'd0);
    #3;
    Reset_n = 1'b1;
    feed(1'b1);
    chk("rp_no_match", {31'd0, m0}, 32'd0);
    chk("rp_st1", {28'd0, st0}, 32'd1);

    // Saturation with a 2-bit counter.
    do_clear();
    chk("sat_start", {30'd0, cnt2}, 32'd0);
    for (int m = 0; m < 5; m++) begin
      feed(1'b1);
      feed(1'b1);
      feed(1'b0);
      feed(1'b1);
      chk($sformatf("sat_m%0d", m), {31'd0, m2}, 32'd1);
      chk($sformatf("sat_cnt%0d", m), {30'd0, cnt2}, {30'd0, sat_exp[m]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_next.md
Name: seq_detect_next

Overview:
- Next-state and control stage that sits directly upstream of the 4-bit FSM state register. It consumes that register's `state` and drives its `next_state`.
- It detects the serial pattern 1101, with overlap, on a valid/ready bit stream.
- It registers a match pulse, a saturating match counter and a sticky illegal-state error, for use by downstream control.

Parameters:
- CNT_W, 8, width of the match counter.
- PAUSE_ON_MATCH, 1: when 1, In_ready drops for exactly one cycle after an accepted bit completes a match.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- In_valid  in  1  serial bit valid.
- In_bit  in  1  serial data bit.
- In_ready  out  1  stage can accept a bit this cycle.
- Clear  in  1  synchronous clear of detector, counter and error.
- state  in  4  current state, fed back from the downstream state register.
- next_state  out  4  combinational next state, to the state register.
- Match  out  1  registered one-cycle pulse, pattern completed.
- Match_count  out  CNT_W  registered saturating count of matches.
- Err  out  1  registered sticky flag, illegal state code seen.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (Clk, Reset_n). All flops in this block clear immediately when Reset_n is low.
- Reset values: Match=0, Match_count=0, Err=0, pause flop=0, In_ready=1. next_state=S_IDLE while Reset_n is low.
- State encoding, 4 bits: S_IDLE=0, S_1=1, S_11=2, S_110=3, S_MATCH=4. Codes 5..15 are illegal.
- accept = In_valid & In_ready. When accept=0, next_state=state for legal codes (hold).
- Transitions on accept, written as bit 0 / bit 1:
  - S_IDLE: 0->S_IDLE, 1->S_1.
  - S_1: 0->S_IDLE, 1->S_11.
  - S_11: 0->S_110, 1->S_11.
  - S_110: 0->S_IDLE, 1->S_MATCH.
  - S_MATCH: 0->S_IDLE, 1->S_11 (overlap suffix "1" is retained).
- Illegal state code, regardless of accept: next_state=S_IDLE. Err is set at the next edge. Any bit offered that cycle is consumed and discarded.
- Clear=1: next_state=S_IDLE and accepted bits are discarded. At the next edge Match_count=0, Err=0, Match=0 and pause=0. Clear wins over a simultaneous accept, match or illegal state.
- Match timing:
  - Match is registered. It equals 1 in the cycle after the edge at which an accepted bit drove next_state=S_MATCH.
  - So Match is high in the same cycle the state register shows S_MATCH.
  - Latency is one cycle from the accept of the final 1.
- Match_count increments on that same edge. It saturates at 2^CNT_W-1 and never wraps.
- Pause:
  - PAUSE_ON_MATCH=1: the pause flop is set on a match edge and cleared on the following edge. In_ready = ~pause, so In_ready is low for exactly the cycle that Match is high.
  - PAUSE_ON_MATCH=0: In_ready is tied to 1.
- In_valid high while In_ready is low: the bit is not consumed and state holds. The source must keep In_bit stable until accepted.
- Reset_n asserted mid-sequence: partial-pattern progress is lost. After release, detection restarts from S_IDLE.
- Err stays high until Clear or reset. Back-to-back illegal codes do not toggle it.

Decomposition:
- Shared package `seq_detect_pkg`:
  - state localparams S_IDLE..S_MATCH, plus STATE_W=4;
  - the function is_legal(state).
- One natural sub-module: `seq_detect_ctl_regs`, the Match/Match_count/Err/pause register bank with saturation and clear priority.
- The next-state logic stays in the top level as one combinational case block.

Test Plan:
- Reset: hold Reset_n=0 with In_valid=1 -> Match=0, Match_count=0, Err=0, In_ready=1, next_state=0. Release and feed the stream 1,1,0,1 -> Match pulses exactly once, 1 cycle after the last accept; Match_count=1.
- Overlap, PAUSE_ON_MATCH=0: stream 1,1,0,1,1,0,1 with In_valid held high -> two Match pulses, 3 accepts apart; Match_count=2.
- Pause, PAUSE_ON_MATCH=1: stream 1,1,0,1 then keep offering 1 -> In_ready=0 for exactly one cycle; the held bit is accepted on the next cycle; next state is S_11.
- Illegal state: force state=4'hB -> next_state=0; Err=1 from the next cycle; Err stays 1 after state returns legal. Clear=1 for one cycle -> Err=0, Match_count=0.
- Saturation, CNT_W=2: five matches -> Match_count sequence 1,2,3,3,3.
- Clear versus events: Clear=1 in the same cycle as the accept of the final 1 of 1101 -> no Match, Match_count=0, next_state=S_IDLE. Reset_n pulsed low after 1,1,0 -> the following bit 1 does not produce a Match.
